// File: rtl/mem_byte_arb.sv
// Two-master arbiter that turns 32-bit word transfers into four byte cycles on an 8-bit memory.
// Arbitration policy: define MEM_BYTE_ARB_RR_EN for round-robin, leave undefined for fixed priority (m1 wins).
module mem_byte_arb #(
  parameter int ADR_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [ADR_W-1:0] m0_adr,
  input  logic [3:0]       m0_sel,
  input  logic [31:0]      m0_dat_i,
  output logic [31:0]      m0_dat_o,
  output logic             m0_ack,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [ADR_W-1:0] m1_adr,
  input  logic [3:0]       m1_sel,
  input  logic [31:0]      m1_dat_i,
  output logic [31:0]      m1_dat_o,
  output logic             m1_ack,
  output logic [ADR_W-1:0] mem_adr,
  output logic [7:0]       mem_dat_o,
  input  logic [7:0]       mem_dat_i,
  output logic             mem_we,
  output logic             mem_en,
  output logic [1:0]       dbg_state
);

  // Handshake: a master raises req with stable we/adr/sel/dat_i and holds it until its ack,
  // a single-cycle pulse during which dat_o is valid; inputs are only looked at in IDLE.
  typedef enum logic [1:0] {IDLE = 2'd0, BYTE = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [1:0]       k_q;
  logic             gnt_q;
  logic             we_q;
  logic [ADR_W-3:0] wadr_q;
  logic [3:0]       sel_q;
  logic [31:0]      wdat_q;
  logic [31:0]      rd_q;
  logic             cap_q;
  logic [1:0]       cap_lane_q;

  logic             start;
  logic             ack;
  logic             pick;
  logic             lane_en;
  logic [4:0]       wr_off;
  logic [4:0]       cap_off;
  logic [31:0]      rd_view;
  logic             unused_adr_bits;

  assign unused_adr_bits = ^{m0_adr[1:0], m1_adr[1:0]};

`ifdef MEM_BYTE_ARB_RR_EN
  logic last_q;
  assign pick = (m0_req & m1_req) ? ~last_q : m1_req;
`else
  assign pick = m1_req;
`endif

  // Lane k carries bits [31-8k:24-8k]; 3-k equals ~k on two bits.
  assign lane_en = sel_q[~k_q];
  assign wr_off  = {~k_q, 3'b000};
  assign cap_off = {~cap_lane_q, 3'b000};

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    ack       = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_adr   = {wadr_q, k_q};
    mem_dat_o = wdat_q[wr_off +: 8];
    case (state_q)
      IDLE: begin
        if (m0_req | m1_req) begin
          start   = 1'b1;
          state_d = BYTE;
        end
      end
      BYTE: begin
        mem_en = lane_en;
        mem_we = we_q & lane_en;
        if (k_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        ack     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= 2'd0;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      wadr_q     <= '0;
      sel_q      <= 4'd0;
      wdat_q     <= 32'd0;
      rd_q       <= 32'd0;
      cap_q      <= 1'b0;
      cap_lane_q <= 2'd0;
`ifdef MEM_BYTE_ARB_RR_EN
      last_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cap_q      <= (state_q == BYTE) & lane_en & ~we_q;
      cap_lane_q <= k_q;
      if (cap_q) rd_q[cap_off +: 8] <= mem_dat_i;
      if (state_q == BYTE) k_q <= k_q + 2'd1;
      if (start) begin
        gnt_q  <= pick;
        we_q   <= pick ? m1_we : m0_we;
        wadr_q <= pick ? m1_adr[ADR_W-1:2] : m0_adr[ADR_W-1:2];
        sel_q  <= pick ? m1_sel : m0_sel;
        wdat_q <= pick ? m1_dat_i : m0_dat_i;
        k_q    <= 2'd0;
        rd_q   <= 32'd0;
`ifdef MEM_BYTE_ARB_RR_EN
        last_q <= pick;
`endif
      end
    end
  end

  // Lane 3 arrives in DONE, the ack cycle itself, so it is forwarded straight from memory.
  always_comb begin
    rd_view = rd_q;
    if (cap_q) rd_view[cap_off +: 8] = mem_dat_i;
  end

  assign m0_dat_o  = rd_view;
  assign m1_dat_o  = rd_view;
  assign m0_ack    = ack & ~gnt_q;
  assign m1_ack    = ack & gnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_byte_arb.sv
// Directed bench for mem_byte_arb: stub byte memory, per-cycle transaction model, literal spot checks.
module tb_mem_byte_arb;

  localparam int ADR_W = 14;

  logic             clk;
  logic             rst;
  logic             m0_req, m0_we, m1_req, m1_we;
  logic [ADR_W-1:0] m0_adr, m1_adr;
  logic [3:0]       m0_sel, m1_sel;
  logic [31:0]      m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o;
  logic             m0_ack, m1_ack;
  logic [ADR_W-1:0] mem_adr;
  logic [7:0]       mem_dat_o, mem_dat_i;
  logic             mem_we, mem_en;
  logic [1:0]       dbg_state;

  mem_byte_arb #(.ADR_W(ADR_W)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_sel(m0_sel),
    .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_sel(m1_sel),
    .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack(m1_ack),
    .mem_adr(mem_adr), .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i),
    .mem_we(mem_we), .mem_en(mem_en), .dbg_state(dbg_state)
  );

  // clock / reset
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      32'h100: return 8'h00;
      32'h101: return 8'hA5;
      32'h102: return 8'hFF;
      32'h103: return 8'h10;
      default: return 8'((i * 37 + 11) & 255);
    endcase
  endfunction

  // stub memory: registered read, junk when no read is pending
  logic       mem_init;
  logic       junk_all;
  logic [7:0] smem [0:(1<<ADR_W)-1];
  logic [7:0] rq, jq;
  logic       vq;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < (1 << ADR_W); i++) smem[i] <= init_byte(i);
    end else if (mem_en && mem_we) begin
      smem[mem_adr] <= mem_dat_o;
    end
    if (mem_en) rq <= smem[mem_adr];
    vq <= mem_en && !junk_all;
    jq <= 8'($urandom);
  end
  assign mem_dat_i = vq ? rq : jq;

  // scoreboard: transaction-level model checked every cycle
  logic [7:0]  ref_mem [0:(1<<ADR_W)-1];
  int          phase = 0;
  int          m_g = 0;
  int          last_g = 0;
  logic        m_we;
  logic [13:0] m_adr;
  logic [3:0]  m_sel;
  logic [31:0] m_dat;
  logic [31:0] exp_rd;
  int          gnt_log[$];
  int          en_pulses = 0;

  always @(negedge clk) begin
    if (cyc > 0) begin
      if (phase >= 1 && phase <= 4) begin
        int k;
        logic on;
        k  = phase - 1;
        on = m_sel[3-k];
        chk("mem_en", {31'd0, mem_en}, {31'd0, on});
        chk("mem_we", {31'd0, mem_we}, {31'd0, on & m_we});
        if (on) chk("mem_adr", {18'd0, mem_adr}, {18'd0, m_adr[13:2], 2'(k)});
        if (on && m_we) chk("mem_dat_o", {24'd0, mem_dat_o}, {24'd0, m_dat[8*(3-k) +: 8]});
      end else begin
        chk("mem_en_idle", {31'd0, mem_en}, 32'd0);
        chk("mem_we_idle", {31'd0, mem_we}, 32'd0);
      end
      chk("m0_ack", {31'd0, m0_ack}, {31'd0, (phase == 5 && m_g == 0)});
      chk("m1_ack", {31'd0, m1_ack}, {31'd0, (phase == 5 && m_g == 1)});
      if (phase == 5) chk("dat_o", (m_g == 1) ? m1_dat_o : m0_dat_o, exp_rd);
      if (m0_ack) gnt_log.push_back(0);
      if (m1_ack) gnt_log.push_back(1);
      if (mem_en) en_pulses++;
    end
    if (mem_init) begin
      for (int i = 0; i < (1 << ADR_W); i++) ref_mem[i] = init_byte(i);
    end
    if (rst) begin
      phase  = 0;
      last_g = 0;
    end else if (phase == 5) begin
      phase = 0;
    end else if (phase > 0) begin
      phase++;
    end else if (m0_req || m1_req) begin
`ifdef MEM_BYTE_ARB_RR_EN
      m_g = (m0_req && m1_req) ? 1 - last_g : (m1_req ? 1 : 0);
`else
      m_g = m1_req ? 1 : 0;
`endif
      last_g = m_g;
      m_we   = m_g ? m1_we : m0_we;
      m_adr  = m_g ? m1_adr : m0_adr;
      m_sel  = m_g ? m1_sel : m0_sel;
      m_dat  = m_g ? m1_dat_i : m0_dat_i;
      exp_rd = 32'd0;
      for (int j = 0; j < 4; j++) begin
        if (m_sel[3-j]) begin
          if (m_we) ref_mem[{m_adr[13:2], 2'(j)}] = m_dat[8*(3-j) +: 8];
          else exp_rd[8*(3-j) +: 8] = ref_mem[{m_adr[13:2], 2'(j)}];
        end
      end
      phase = 1;
    end
  end

  // driver: call at posedge+1 of an IDLE cycle
  task automatic xfer(input int m, input logic we, input logic [13:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, output logic [31:0] rdat, output int lat);
    int  t0;
    bit  got;
    if (m == 0) begin
      m0_we = we; m0_adr = adr; m0_sel = sel; m0_dat_i = dat; m0_req = 1'b1;
    end else begin
      m1_we = we; m1_adr = adr; m1_sel = sel; m1_dat_i = dat; m1_req = 1'b1;
    end
    t0   = cyc;
    got  = 0;
    lat  = -1;
    rdat = 32'hDEAD_DEAD;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((m == 0) ? m0_ack : m1_ack) begin
        got  = 1;
        lat  = cyc - t0;
        rdat = (m == 0) ? m0_dat_o : m1_dat_o;
        break;
      end
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
  endtask

  logic [31:0] rd;
  int          lat;
  int          e0;
  int          acks;
  int          rem0, rem1;
  int          exp_g[6];

  initial begin
    rst = 1'b1; mem_init = 1'b1; junk_all = 1'b0;
    m0_req = 0; m0_we = 0; m0_adr = '0; m0_sel = 0; m0_dat_i = 0;
    m1_req = 0; m1_we = 0; m1_adr = '0; m1_sel = 0; m1_dat_i = 0;
    repeat (3) @(posedge clk);
    #1;
    mem_init = 1'b0;
    @(negedge clk);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
    chk("rst_rd_reg", m0_dat_o, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // full-word read of known bytes
    xfer(0, 1'b0, 14'h0100, 4'hF, 32'd0, rd, lat);
    chk("rd_word", rd, 32'h00A5FF10);
    chk("rd_latency", lat, 32'd5);

    // sparse write after pre-clearing, then readback
    xfer(1, 1'b1, 14'h2004, 4'hF, 32'd0, rd, lat);
    xfer(1, 1'b1, 14'h2004, 4'b0101, 32'h11223344, rd, lat);
    chk("wr_latency", lat, 32'd5);
    chk("wr_dat_o", rd, 32'd0);
    chk("wr_byte5", {24'd0, smem[14'h2005]}, 32'h22);
    chk("wr_byte7", {24'd0, smem[14'h2007]}, 32'h44);
    chk("wr_byte4", {24'd0, smem[14'h2004]}, 32'h00);
    xfer(1, 1'b0, 14'h2006, 4'hF, 32'd0, rd, lat);
    chk("wr_readback", rd, 32'h00220044);

    // sel=0 read with junk on the memory data bus throughout
    junk_all = 1'b1;
    e0 = en_pulses;
    xfer(0, 1'b0, 14'h0101, 4'h0, 32'd0, rd, lat);
    junk_all = 1'b0;
    chk("sel0_dat", rd, 32'd0);
    chk("sel0_latency", lat, 32'd5);
    chk("sel0_en_pulses", en_pulses - e0, 32'd0);

    // partial lanes, mixed masters
    xfer(0, 1'b1, 14'h0200, 4'b1100, 32'hDEADBEEF, rd, lat);
    xfer(1, 1'b0, 14'h0200, 4'hF, 32'd0, rd, lat);
    chk("half_upper", {16'd0, rd[31:16]}, 32'h0000DEAD);
    xfer(0, 1'b0, 14'h0100, 4'b0110, 32'd0, rd, lat);
    chk("mid_lanes", rd, 32'h00A5FF00);

    // reset during BYTE k=2 of a read
    m0_we = 0; m0_adr = 14'h0100; m0_sel = 4'hF; m0_req = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1; m0_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_mem_en", {31'd0, mem_en}, 32'd0);
    chk("abort_state", {30'd0, dbg_state}, 32'd0);
    acks = 0;
    repeat (8) begin
      if (m0_ack || m1_ack) acks++;
      @(negedge clk);
    end
    chk("abort_no_ack", acks, 32'd0);
    @(posedge clk); #1;
    xfer(0, 1'b0, 14'h0100, 4'hF, 32'd0, rd, lat);
    chk("after_abort", rd, 32'h00A5FF10);

    // contention: three transfers each, last grant was m0
    m0_we = 0; m0_adr = 14'h0104; m0_sel = 4'hF;
    m1_we = 0; m1_adr = 14'h0108; m1_sel = 4'hA;
    gnt_log.delete();
    rem0 = 3; rem1 = 3;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 100 && (rem0 > 0 || rem1 > 0); i++) begin
      @(negedge clk);
      if (m0_ack) rem0--;
      if (m1_ack) rem1--;
      @(posedge clk); #1;
      m0_req = (rem0 > 0);
      m1_req = (rem1 > 0);
    end
    if (rem0 > 0 || rem1 > 0) chk("contend_timeout", 32'd0, 32'd1);
`ifdef MEM_BYTE_ARB_RR_EN
    exp_g = '{1, 0, 1, 0, 1, 0};
`else
    exp_g = '{1, 1, 1, 0, 0, 0};
`endif
    chk("grant_count", gnt_log.size(), 32'd6);
    for (int i = 0; i < 6 && i < gnt_log.size(); i++) chk($sformatf("grant_%0d", i), gnt_log[i], exp_g[i]);

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_byte_arb.md
MEM_BYTE_ARB -- requirements
Module: mem_byte_arb

Interface
REQ-001 Parameter ADR_W, default 14, byte-address width of the 8-bit memory.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 mN_req  input  1  (N=0 fetch, N=1 data) transfer request, held until mN_ack.
REQ-005 mN_we  input  1  1=write, 0=read.
REQ-006 mN_adr  input  ADR_W  byte address; bits [1:0] ignored, word-aligned.
REQ-007 mN_sel  input  4  byte-lane select; sel[3]=bits 31:24=offset 0 (big-endian).
REQ-008 mN_dat_i  input  32  write data.
REQ-009 mN_dat_o  output  32  read data, valid while mN_ack=1.
REQ-010 mN_ack  output  1  one-cycle transfer-complete pulse.
REQ-011 mem_adr  output  ADR_W  byte address to memory.
REQ-012 mem_dat_o  output  8  write byte to memory.
REQ-013 mem_dat_i  input  8  read byte from memory; registered, valid 1 cycle after enabled address; undefined/Z otherwise.
REQ-014 mem_we  output  1  memory write enable.
REQ-015 mem_en  output  1  memory enable.

Function
REQ-016 FSM states IDLE, BYTE, DONE; BYTE steps a 2-bit counter k=0..3.
REQ-017 IDLE: any mN_req=1 -> latch grant, we, adr[ADR_W-1:2], sel, dat_i; k=0; go BYTE; else stay.
REQ-018 BYTE cycle k: mem_adr={adr[ADR_W-1:2],k}; mem_en=sel[3-k]; mem_we=we&sel[3-k]; mem_dat_o=dat_i[31-8k:24-8k].
REQ-019 Read capture: lane of cycle k loaded from mem_dat_i in the following cycle only if en was set in cycle k; unselected lanes read 0.
REQ-020 k=3 -> DONE; DONE captures lane 3 and asserts granted mN_ack=1 for exactly one cycle, then IDLE.
REQ-021 Fixed latency: req sampled in IDLE at cycle T -> ack in cycle T+5, independent of sel and we.
REQ-022 sel=0: four BYTE cycles with mem_en=0, ack at T+5, dat_o=0.
REQ-023 mem_en=mem_we=0 in IDLE and DONE; mem_adr/mem_dat_o don't-care there.
REQ-024 Both mN_dat_o driven from one shared read register; only the granted ack pulses; write transfers return dat_o=0.
REQ-025 Request inputs ignored outside IDLE; req dropped mid-transfer -> transfer still completes and acks.
REQ-026 Requester deasserts req or presents a new request in the cycle after ack; IDLE re-arbitrates that cycle (min 6 cycles per transfer).
REQ-027 Simultaneous m0_req and m1_req in IDLE: winner per REQ-031; loser stays pending with no ack.

Reset
REQ-028 rst=1 at any edge -> IDLE, k=0, all mN_ack=0, mem_en=0, mem_we=0, read register 0, last-grant=m0.
REQ-029 Reset mid-transfer aborts it; no ack issued; partial writes already performed are not undone.

Configuration
REQ-030 Macro MEM_BYTE_ARB_RR_EN selects the arbitration policy.
REQ-031 Defined: round-robin; on contention, the master not granted last wins; last-grant updates on each grant. Undefined: fixed priority, m1 always wins; no last-grant state.

Verification
REQ-032 m0 read adr=0x0100 sel=4'hF, memory bytes 00,A5,FF,10 -> mem_en 4 cycles at 0x100..0x103, m0_ack at T+5, m0_dat_o=0x00A5FF10.
REQ-033 m1 write adr=0x2004 sel=4'b0101 dat=0x11223344 -> writes only 0x2005=22 and 0x2007=44; m1_ack at T+5; readback 0x00220044 with sel=4'hF after pre-clearing.
REQ-034 m0,m1 req same cycle, 3 transfers each -> RR defined: grants 1,0,1,0,1,0; undefined: 1,1,1,0,0,0.
REQ-035 rst asserted during BYTE k=2 of a read -> next cycle IDLE, mem_en=0, no ack; following request completes normally.
REQ-036 sel=0 read -> no mem_en pulse, ack at T+5, dat_o=0; mem_dat_i forced Z throughout does not corrupt dat_o.
